// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Issues one-cycle datapath enables and qualifies controlunit outputs against the shared memory port.
module core_sequencer #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [4:0]       opcode,
   input  logic             trap,
   input  logic             cu_reg_wen,
   input  logic             cu_mem_rw,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             ir_wen,
   output logic             pc_wen,
   output logic             reg_wen,
   output logic [2:0]       state,
   output logic             halted,
   output logic [1:0]       fault,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6
   } state_t;

   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_STORE = 5'b01000;

   localparam logic [1:0] FLT_NONE  = 2'b00;
   localparam logic [1:0] FLT_TRAP  = 2'b01;
   localparam logic [1:0] FLT_FETCH = 2'b10;
   localparam logic [1:0] FLT_DATA  = 2'b11;

   // The counter only ever needs to reach TIMEOUT-1: that cycle decides ack vs. fault.
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit TIMEOUT_EN = (TIMEOUT > 0);

   state_t            cur;
   logic [WAIT_W-1:0] wait_cnt;
   logic              is_mem_op;
   logic              is_store;
   logic              wait_expired;

   assign is_mem_op    = (opcode == OP_LOAD) || (opcode == OP_STORE);
   assign is_store     = (opcode == OP_STORE);
   assign wait_expired = TIMEOUT_EN && (wait_cnt == WAIT_LAST) && !mem_ready;

   assign state  = cur;
   assign halted = (cur == HALT);

   // Strobes are decoded from the current state so they rise and fall with it, one cycle each.
   always_comb begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_wen  = 1'b0;
      pc_wen  = 1'b0;
      reg_wen = 1'b0;
      case (cur)
         FETCH: begin
            mem_req = 1'b1;
            ir_wen  = mem_ready;
         end
         MEM: begin
            mem_req = 1'b1;
            mem_we  = cu_mem_rw;
            pc_wen  = mem_ready && is_store;
         end
         WB: begin
            pc_wen  = 1'b1;
            reg_wen = cu_reg_wen;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur      <= IDLE;
         fault    <= FLT_NONE;
         instret  <= '0;
         wait_cnt <= '0;
      end else begin
         wait_cnt <= '0;
         case (cur)
            IDLE: begin
               if (run) cur <= FETCH;
            end
            FETCH: begin
               if (mem_ready) begin
                  cur <= DECODE;
               end else if (wait_expired) begin
                  cur   <= HALT;
                  fault <= FLT_FETCH;
               end else if (TIMEOUT_EN) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DECODE: begin
               if (trap) begin
                  cur   <= HALT;
                  fault <= FLT_TRAP;
               end else begin
                  cur <= EXEC;
               end
            end
            EXEC: begin
               cur <= is_mem_op ? MEM : WB;
            end
            MEM: begin
               if (mem_ready) begin
                  if (is_store) begin
                     // Stores retire straight out of MEM; there is nothing to write back.
                     instret <= instret + 1'b1;
                     cur     <= run ? FETCH : IDLE;
                  end else begin
                     cur <= WB;
                  end
               end else if (wait_expired) begin
                  cur   <= HALT;
                  fault <= FLT_DATA;
               end else if (TIMEOUT_EN) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            WB: begin
               instret <= instret + 1'b1;
               cur     <= run ? FETCH : IDLE;
            end
            HALT: ;
            default: cur <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_sequencer.sv
// Vector-table bench for core_sequencer: each row drives one cycle and checks the outputs
// seen during that cycle; rows go through a scoreboard queue between drive and compare.
module tb_core_sequencer;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 4;

   localparam logic [4:0] ADD = 5'b01100;
   localparam logic [4:0] LD  = 5'b00000;
   localparam logic [4:0] ST  = 5'b01000;
   localparam logic [4:0] BR  = 5'b11000;

   // strobe order: mem_req, mem_we, ir_wen, pc_wen, reg_wen
   localparam logic [4:0] S0   = 5'b00000;
   localparam logic [4:0] SREQ = 5'b10000;
   localparam logic [4:0] SIR  = 5'b10100;
   localparam logic [4:0] SST  = 5'b11000;
   localparam logic [4:0] SSTA = 5'b11010;
   localparam logic [4:0] SWB  = 5'b00011;
   localparam logic [4:0] SPC  = 5'b00010;

   localparam logic [2:0] I = 3'd0, F = 3'd1, D = 3'd2, E = 3'd3, M = 3'd4, W = 3'd5, H = 3'd6;

   typedef struct {
      string      name;
      logic       rst;
      logic       run;
      logic [4:0] op;
      logic       trap;
      logic       crw;
      logic       cmw;
      logic       rdy;
      logic [2:0] st;
      logic [4:0] sb;
      logic [1:0] flt;
      logic [3:0] ret;
   } vec_t;

   logic             clk, rst, run, trap, cu_reg_wen, cu_mem_rw, mem_ready;
   logic [4:0]       opcode;
   logic             mem_req, mem_we, ir_wen, pc_wen, reg_wen, halted;
   logic [2:0]       state;
   logic [1:0]       fault;
   logic [CNT_W-1:0] instret;

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];
   vec_t exp_q[$];

   core_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .trap(trap),
      .cu_reg_wen(cu_reg_wen), .cu_mem_rw(cu_mem_rw), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .ir_wen(ir_wen), .pc_wen(pc_wen),
      .reg_wen(reg_wen), .state(state), .halted(halted), .fault(fault), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t v(input string n, input logic r, input logic rn, input logic [4:0] op,
                              input logic tp, input logic crw, input logic cmw, input logic rdy,
                              input logic [2:0] st, input logic [4:0] sb, input logic [1:0] flt,
                              input logic [3:0] ret);
      vec_t t;
      t.name = n; t.rst = r; t.run = rn; t.op = op; t.trap = tp; t.crw = crw; t.cmw = cmw;
      t.rdy = rdy; t.st = st; t.sb = sb; t.flt = flt; t.ret = ret;
      return t;
   endfunction

   task automatic apply(input vec_t t, input int idx);
      vec_t        e;
      logic [14:0] act, want;
      @(negedge clk);
      rst = t.rst; run = t.run; opcode = t.op; trap = t.trap;
      cu_reg_wen = t.crw; cu_mem_rw = t.cmw; mem_ready = t.rdy;
      exp_q.push_back(t);
      #1;
      e    = exp_q.pop_front();
      act  = {mem_req, mem_we, ir_wen, pc_wen, reg_wen, halted, fault, state, instret};
      want = {e.sb, (e.st == H), e.flt, e.st, e.ret};
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s row %0d: got strb=%b halt=%b flt=%b st=%0d ret=%0d want strb=%b halt=%b flt=%b st=%0d ret=%0d",
                  e.name, idx, act[14:10], act[9], act[8:7], act[6:4], act[3:0],
                  want[14:10], want[9], want[8:7], want[6:4], want[3:0]);
      end
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; opcode = '0; trap = 1'b0;
      cu_reg_wen = 1'b0; cu_mem_rw = 1'b0; mem_ready = 1'b0;

      //      name          rst run op   trp crw cmw rdy  st  strobes flt    ret
      tbl.push_back(v("rst_idle",   0, 0, ADD, 0, 1, 0, 0, I, S0,   2'b00, 0));
      // ADD, single-cycle fetch ack, back-to-back into the LOAD
      tbl.push_back(v("add_idle",   0, 1, ADD, 0, 1, 0, 0, I, S0,   2'b00, 0));
      tbl.push_back(v("add_fetch",  0, 1, ADD, 0, 1, 0, 1, F, SIR,  2'b00, 0));
      tbl.push_back(v("add_dec",    0, 1, ADD, 0, 1, 0, 0, D, S0,   2'b00, 0));
      tbl.push_back(v("add_exec",   0, 1, ADD, 0, 1, 0, 0, E, S0,   2'b00, 0));
      tbl.push_back(v("add_wb",     0, 1, ADD, 0, 1, 0, 0, W, SWB,  2'b00, 0));
      // LOAD with data ack two cycles late
      tbl.push_back(v("ld_fetch",   0, 1, LD,  0, 1, 0, 1, F, SIR,  2'b00, 1));
      tbl.push_back(v("ld_dec",     0, 1, LD,  0, 1, 0, 0, D, S0,   2'b00, 1));
      tbl.push_back(v("ld_exec",    0, 1, LD,  0, 1, 0, 0, E, S0,   2'b00, 1));
      tbl.push_back(v("ld_mem0",    0, 1, LD,  0, 1, 0, 0, M, SREQ, 2'b00, 1));
      tbl.push_back(v("ld_mem1",    0, 1, LD,  0, 1, 0, 0, M, SREQ, 2'b00, 1));
      tbl.push_back(v("ld_mem_ack", 0, 1, LD,  0, 1, 0, 1, M, SREQ, 2'b00, 1));
      tbl.push_back(v("ld_wb",      0, 1, LD,  0, 1, 0, 0, W, SWB,  2'b00, 1));
      // STORE; stray mem_ready in DECODE/EXEC is ignored; run drops on the MEM ack
      tbl.push_back(v("st_fetch",   0, 1, ST,  0, 0, 1, 1, F, SIR,  2'b00, 2));
      tbl.push_back(v("st_dec",     0, 1, ST,  0, 0, 1, 1, D, S0,   2'b00, 2));
      tbl.push_back(v("st_exec",    0, 1, ST,  0, 0, 1, 1, E, S0,   2'b00, 2));
      tbl.push_back(v("st_mem0",    0, 1, ST,  0, 0, 1, 0, M, SST,  2'b00, 2));
      tbl.push_back(v("st_mem_ack", 0, 0, ST,  0, 0, 1, 1, M, SSTA, 2'b00, 2));
      tbl.push_back(v("st_stop",    0, 0, ST,  0, 0, 1, 0, I, S0,   2'b00, 3));
      tbl.push_back(v("idle_hold",  0, 0, ST,  0, 0, 0, 1, I, S0,   2'b00, 3));
      // branch: one fetch wait, controlunit keeps reg_wen low
      tbl.push_back(v("br_idle",    0, 1, BR,  0, 0, 0, 0, I, S0,   2'b00, 3));
      tbl.push_back(v("br_fwait",   0, 1, BR,  0, 0, 0, 0, F, SREQ, 2'b00, 3));
      tbl.push_back(v("br_fetch",   0, 1, BR,  0, 0, 0, 1, F, SIR,  2'b00, 3));
      tbl.push_back(v("br_dec",     0, 1, BR,  0, 0, 0, 0, D, S0,   2'b00, 3));
      tbl.push_back(v("br_exec",    0, 1, BR,  0, 0, 0, 0, E, S0,   2'b00, 3));
      tbl.push_back(v("br_wb",      0, 0, BR,  0, 0, 0, 0, W, SPC,  2'b00, 3));
      tbl.push_back(v("br_stop",    0, 0, BR,  0, 0, 0, 0, I, S0,   2'b00, 4));
      // illegal instruction traps in DECODE
      tbl.push_back(v("trap_idle",  0, 1, ADD, 0, 1, 0, 0, I, S0,   2'b00, 4));
      tbl.push_back(v("trap_fetch", 0, 1, ADD, 0, 1, 0, 1, F, SIR,  2'b00, 4));
      tbl.push_back(v("trap_dec",   0, 1, ADD, 1, 1, 0, 0, D, S0,   2'b00, 4));
      tbl.push_back(v("trap_halt",  0, 1, ADD, 0, 1, 0, 1, H, S0,   2'b01, 4));
      tbl.push_back(v("trap_hold",  0, 1, ADD, 0, 1, 0, 0, H, S0,   2'b01, 4));
      tbl.push_back(v("trap_rst",   1, 1, ADD, 0, 1, 0, 0, H, S0,   2'b01, 4));
      tbl.push_back(v("trap_clr",   0, 0, ADD, 0, 1, 0, 0, I, S0,   2'b00, 0));
      // reset while mem_req is high in FETCH
      tbl.push_back(v("mrst_idle",  0, 1, ADD, 0, 0, 0, 0, I, S0,   2'b00, 0));
      tbl.push_back(v("mrst_fetch", 0, 1, ADD, 0, 0, 0, 0, F, SREQ, 2'b00, 0));
      tbl.push_back(v("mrst_rst",   1, 1, ADD, 0, 0, 0, 0, F, SREQ, 2'b00, 0));
      tbl.push_back(v("mrst_idle2", 0, 1, ADD, 0, 0, 0, 0, I, S0,   2'b00, 0));
      // fetch timeout: 16 wait cycles with mem_req high, then HALT
      for (int k = 0; k < TIMEOUT; k++)
         tbl.push_back(v("fto_wait",0, 1, ADD, 0, 0, 0, 0, F, SREQ, 2'b00, 0));
      tbl.push_back(v("fto_halt",   0, 1, ADD, 0, 0, 0, 1, H, S0,   2'b10, 0));
      tbl.push_back(v("fto_rst",    1, 1, ADD, 0, 0, 0, 0, H, S0,   2'b10, 0));
      // ack on the last allowed fetch cycle wins, then the data phase times out
      tbl.push_back(v("dto_idle",   0, 1, LD,  0, 1, 0, 0, I, S0,   2'b00, 0));
      for (int k = 0; k < TIMEOUT - 1; k++)
         tbl.push_back(v("late_wait",0, 1, LD, 0, 1, 0, 0, F, SREQ, 2'b00, 0));
      tbl.push_back(v("late_ack",   0, 1, LD,  0, 1, 0, 1, F, SIR,  2'b00, 0));
      tbl.push_back(v("dto_dec",    0, 1, LD,  0, 1, 0, 0, D, S0,   2'b00, 0));
      tbl.push_back(v("dto_exec",   0, 1, LD,  0, 1, 0, 0, E, S0,   2'b00, 0));
      for (int k = 0; k < TIMEOUT; k++)
         tbl.push_back(v("dto_wait",0, 1, LD,  0, 1, 0, 0, M, SREQ, 2'b00, 0));
      tbl.push_back(v("dto_halt",   0, 1, LD,  0, 1, 0, 0, H, S0,   2'b11, 0));
      tbl.push_back(v("dto_rst",    1, 0, LD,  0, 1, 0, 0, H, S0,   2'b11, 0));
      // sixteen retires wrap the 4-bit counter back to zero
      tbl.push_back(v("wrap_idle",  0, 1, ADD, 0, 1, 0, 0, I, S0,   2'b00, 0));
      for (int k = 0; k < 16; k++) begin
         logic [3:0] r;
         logic       more;
         r    = 4'(k);
         more = (k != 15);
         tbl.push_back(v("wrap_fetch",0, 1, ADD, 0, 1, 0, 1, F, SIR, 2'b00, r));
         tbl.push_back(v("wrap_dec", 0, 1, ADD, 0, 1, 0, 0, D, S0,   2'b00, r));
         tbl.push_back(v("wrap_exec",0, 1, ADD, 0, 1, 0, 0, E, S0,   2'b00, r));
         tbl.push_back(v("wrap_wb",  0, more, ADD, 0, 1, 0, 0, W, SWB, 2'b00, r));
      end
      tbl.push_back(v("wrap_zero",  0, 0, ADD, 0, 1, 0, 0, I, S0,   2'b00, 0));

      repeat (2) @(posedge clk);
      foreach (tbl[i]) apply(tbl[i], i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
